// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder: FSM state and the output event bundle.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DOWN,
        LONG
    } btn_state_e;

    typedef struct packed {
        logic press;
        logic rel;
        logic long_press;
        logic rpt;
        logic dclick;
    } btn_events_t;

endpackage

// File: rtl/button_event_decoder_sat_counter.sv
// Unsigned counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned           COUNTER_WIDTH = 16,
    parameter logic [COUNTER_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [COUNTER_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Converts a debounced key level into single-cycle Press/Release/LongPress/Repeat/DoubleClick
// pulses plus a Held level.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH       = 16,
    parameter int unsigned LONG_PRESS_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES       = 10000,
    parameter int unsigned DOUBLE_CLICK_CYCLES = 20000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Input,
    output logic Press,
    output logic Release,
    output logic LongPress,
    output logic Repeat,
    output logic DoubleClick,
    output logic Held
);

    localparam longint unsigned CNT_MAX = (64'd1 << COUNTER_WIDTH) - 64'd1;

    if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 32) begin : g_bad_width
        $fatal(1, "COUNTER_WIDTH must be in 1..32");
    end
    if (LONG_PRESS_CYCLES < 1 || 64'(LONG_PRESS_CYCLES) > CNT_MAX) begin : g_bad_long
        $fatal(1, "LONG_PRESS_CYCLES out of range for COUNTER_WIDTH");
    end
    if (64'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
        $fatal(1, "REPEAT_CYCLES out of range for COUNTER_WIDTH");
    end
    if (64'(DOUBLE_CLICK_CYCLES) > CNT_MAX) begin : g_bad_dclick
        $fatal(1, "DOUBLE_CLICK_CYCLES out of range for COUNTER_WIDTH");
    end

    localparam logic [COUNTER_WIDTH-1:0] LONG_LAST  = COUNTER_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] REP_LAST   =
        COUNTER_WIDTH'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] DCLICK_LIM = COUNTER_WIDTH'(DOUBLE_CLICK_CYCLES);

    btn_state_e               state;
    btn_events_t              ev;
    logic                     in_prev;
    logic                     held;
    logic                     short_flag;
    logic                     dc_press;
    logic [COUNTER_WIDTH-1:0] hold_cnt;
    logic [COUNTER_WIDTH-1:0] gap_cnt;
    logic                     rise, fall;
    logic                     long_hit, rep_hit, dc_ok;
    logic                     hold_clr, hold_en, gap_clr, gap_en;

    always_comb begin
        rise     = Input & ~in_prev;
        fall     = ~Input & in_prev;
        long_hit = (hold_cnt == LONG_LAST);
        rep_hit  = (REPEAT_CYCLES != 0) && (hold_cnt == REP_LAST);
        dc_ok    = (DOUBLE_CLICK_CYCLES != 0) && short_flag && (gap_cnt < DCLICK_LIM);
        hold_clr = 1'b0;
        hold_en  = 1'b0;
        gap_clr  = 1'b0;
        gap_en   = 1'b0;
        unique case (state)
            IDLE: begin
                hold_clr = rise;
                gap_en   = ~rise;
            end
            DOWN: begin
                gap_clr  = fall;
                hold_clr = ~fall & long_hit;
                hold_en  = ~fall & ~long_hit;
            end
            LONG: begin
                gap_clr  = fall;
                hold_clr = ~fall & rep_hit;
                hold_en  = ~fall & ~rep_hit;
            end
            default: ;
        endcase
    end

    sat_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .RESET_VALUE  ('0)
    ) u_hold_cnt (
        .clk  (Clk),
        .rst_n(Rst_n),
        .clr  (hold_clr),
        .en   (hold_en),
        .count(hold_cnt)
    );

    sat_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .RESET_VALUE  ('1)
    ) u_gap_cnt (
        .clk  (Clk),
        .rst_n(Rst_n),
        .clr  (gap_clr),
        .en   (gap_en),
        .count(gap_cnt)
    );

    // dc_press keeps the release of a double-click press from re-arming another double-click.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            in_prev    <= 1'b0;
            held       <= 1'b0;
            short_flag <= 1'b0;
            dc_press   <= 1'b0;
            ev         <= '0;
        end else begin
            in_prev <= Input;
            ev      <= '0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= DOWN;
                        held       <= 1'b1;
                        ev.press   <= 1'b1;
                        ev.dclick  <= dc_ok;
                        dc_press   <= dc_ok;
                        short_flag <= 1'b0;
                    end
                end
                DOWN: begin
                    if (fall) begin
                        state      <= IDLE;
                        held       <= 1'b0;
                        ev.rel     <= 1'b1;
                        short_flag <= ~dc_press;
                    end else if (long_hit) begin
                        state         <= LONG;
                        ev.long_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state      <= IDLE;
                        held       <= 1'b0;
                        ev.rel     <= 1'b1;
                        short_flag <= 1'b0;
                    end else if (rep_hit) begin
                        ev.rpt <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

    assign Press       = ev.press;
    assign Release     = ev.rel;
    assign LongPress   = ev.long_press;
    assign Repeat      = ev.rpt;
    assign DoubleClick = ev.dclick;
    assign Held        = held;

endmodule
